// File: rtl/neuron_accumulator.sv
// neuron_accumulator: per-neuron accumulate-and-activate stage.
// Loads a sign-magnitude bias on start, sums N_IN sign-magnitude products into a
// WIDTH+GUARD bit two's-complement accumulator, ORs the multiplier's invalid/ovf
// flags into sticky per-evaluation flags, then saturates to +-(2^(WIDTH-1)-1) and
// presents the sign-magnitude result with a valid/ready handshake.
// Optional feature macro: NEURON_RELU_EN (ReLU after saturation; negative -> 0x0000).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, bias_i       begin evaluation and load bias (IDLE only)
//   prod_valid_i, prod_i  product handshake / data (sign-magnitude)
//   prod_invalid_i        multiplier TMR disagreement flag for this product
//   prod_ovf_i            multiplier overflow flag for this product
//   prod_ready_o          product accepted this cycle (ACC state)
//   out_valid_o, out_ready_i, out_data_o, out_err_o, out_sat_o  result handshake
module neuron_accumulator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IBITS = 6,
  parameter int unsigned FBITS = 10,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned GUARD = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] bias_i,
  input  logic             prod_valid_i,
  input  logic [WIDTH-1:0] prod_i,
  input  logic             prod_invalid_i,
  input  logic             prod_ovf_i,
  output logic             prod_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_err_o,
  output logic             out_sat_o
);

  localparam int unsigned AccW = WIDTH + GUARD;
  localparam int unsigned CntW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [AccW-1:0] PosLim = AccW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [AccW-1:0] NegLim = -PosLim;

  if (IBITS + FBITS != WIDTH) begin : g_bad_format
    $error("IBITS + FBITS must equal WIDTH");
  end
  if (N_IN < 1 || (N_IN + 1) > (1 << GUARD)) begin : g_bad_guard
    $error("N_IN must be >= 1 and N_IN+1 terms must fit in 2^GUARD");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StFin, StOut} state_e;

  state_e                 state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   sat_q, sat_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_err_q, out_err_d;
  logic                   out_sat_q, out_sat_d;

  // Negative zero maps to 0 naturally since -0 == 0 in two's complement.
  function automatic logic signed [AccW-1:0] sm_to_tc(input logic [WIDTH-1:0] sm);
    logic signed [AccW-1:0] mag;
    mag = AccW'(sm[WIDTH-2:0]);
    return sm[WIDTH-1] ? -mag : mag;
  endfunction

  // Saturation and sign-magnitude conversion of the current accumulator.
  logic                   clamp_hi, clamp_lo, neg;
  logic signed [AccW-1:0] acc_clamped;
  logic [WIDTH-2:0]       abs_val;
  logic [WIDTH-1:0]       fin_data;
  logic                   fin_sat;

  always_comb begin
    clamp_hi    = acc_q > PosLim;
    clamp_lo    = acc_q < NegLim;
    acc_clamped = clamp_hi ? PosLim : (clamp_lo ? NegLim : acc_q);
    neg         = acc_clamped[AccW-1];
    abs_val     = neg ? (WIDTH-1)'(-acc_clamped) : (WIDTH-1)'(acc_clamped);
`ifdef NEURON_RELU_EN
    fin_data    = neg ? '0 : {1'b0, abs_val};
    fin_sat     = sat_q | clamp_hi;
`else
    fin_data    = {neg, abs_val};
    fin_sat     = sat_q | clamp_hi | clamp_lo;
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d   = sm_to_tc(bias_i);
          cnt_d   = '0;
          err_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (prod_valid_i) begin
          acc_d = acc_q + sm_to_tc(prod_i);
          err_d = err_q | prod_invalid_i;
          sat_d = sat_q | prod_ovf_i;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N_IN - 1)) state_d = StFin;
        end
      end
      StFin: begin
        out_data_d = fin_data;
        out_err_d  = err_q;
        out_sat_d  = fin_sat;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign prod_ready_o = (state_q == StAcc);
  assign out_valid_o  = (state_q == StOut);
  assign out_data_o   = out_data_q;
  assign out_err_o    = out_err_q;
  assign out_sat_o    = out_sat_q;

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Sequential accumulate-and-activate stage that sits directly downstream of the fault-tolerant multiplier in each neuron. It consumes one product per handshake, sums N_IN products onto a bias in a widened two's-complement accumulator, and ORs the multiplier's `invalid` and `ovf` flags into per-evaluation sticky flags. It then saturates the result back to the 16-bit sign-magnitude fixed-point format and presents it with a valid/ready handshake to the next layer.

## Interface
- `WIDTH`, 16, total word width; sign-magnitude, bit WIDTH-1 = sign.
- `IBITS`, 6, integer bits including the sign bit.
- `FBITS`, 10, fractional bits (IBITS+FBITS = WIDTH).
- `N_IN`, 2, products summed per evaluation (≥1).
- `GUARD`, 4, extra accumulator bits; accumulator is WIDTH+GUARD bits, two's complement.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin an evaluation and load `bias`; honoured only in IDLE.
- `bias`  in  WIDTH  sign-magnitude bias, sampled with `start`.
- `prod_valid`  in  1  product word valid.
- `prod`  in  WIDTH  sign-magnitude product from the multiplier.
- `prod_invalid`  in  1  multiplier's TMR disagreement flag for this product.
- `prod_ovf`  in  1  multiplier's overflow flag for this product.
- `prod_ready`  out  1  stage accepts a product this cycle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  sign-magnitude result.
- `out_err`  out  1  at least one accepted product had `prod_invalid`=1.
- `out_sat`  out  1  at least one `prod_ovf`=1, or the final result was saturated.

## Operation
- FSM states: IDLE, ACC, FIN, OUT.
- **IDLE:**
  - `prod_ready`=0 and `out_valid`=0.
  - On `start`: acc ← two's-complement(`bias`), count ← 0, err ← 0, sat ← 0, go to ACC.
- **ACC:**
  - `prod_ready`=1.
  - On accept (`prod_valid`&`prod_ready`): acc ← acc + two's-complement(`prod`), err |= `prod_invalid`, sat |= `prod_ovf`, count++.
  - On the accept where count = N_IN-1, go to FIN.
- **FIN** (one cycle):
  - Clamp acc to ±(2^(WIDTH-1)-1); set sat if clamped.
  - Convert to sign-magnitude and register into `out_data`, `out_err`, `out_sat`.
  - Go to OUT.
- **OUT:**
  - `out_valid`=1; `out_data`, `out_err` and `out_sat` are held stable.
  - On `out_ready`, go to IDLE in the next cycle.
- Negative zero (0x8000) on `bias` or `prod` is treated as +0. `out_data` is never 0x8000; a zero result is 0x0000.
- `start` is ignored outside IDLE.
- `prod_valid` is ignored outside ACC; no product is consumed.
- Accumulator overflow cannot occur for N_IN+1 ≤ 2^GUARD terms; this is a parameter legality requirement.
- Reset:
  - All outputs are 0, the FSM returns to IDLE, and acc, count and flags are cleared.
  - Reset mid-evaluation discards partial sums.

## Timing
- Bias load: `start` sampled in IDLE at edge t puts the FSM in ACC at t+1; `prod_ready`=1 from t+1.
- Throughput: one product per cycle in ACC.
- Latency: last product accepted at edge k → FIN during cycle k+1 → `out_valid`=1 after edge k+2.
- Minimum evaluation, start to `out_valid`: N_IN+2 cycles.
- Result transfer occurs at the edge where `out_valid`&`out_ready`. `out_valid` drops the cycle after; earliest next `start` is sampled in that cycle.
- `prod_ready` is a registered state decode with no combinational path from `prod_valid`. `out_valid` is likewise registered.
- `rst` has priority over every other input on the same edge.

## Configuration
- `NEURON_RELU_EN`
  - Defined: FIN applies ReLU after saturation. Any negative result produces `out_data`=0x0000. `out_sat` reflects only positive clamping and `prod_ovf`.
  - Undefined: linear output; negative results are passed as saturated sign-magnitude values.

## Test plan
- **Basic sum.** bias=0x0000, products 0x0066 then 0x000A, flags 0 → `out_data`=0x0070, `out_err`=0, `out_sat`=0. `out_valid` rises 2 cycles after the second accept.
- **Mixed signs.** bias=0x0400, products 0x060F and 0x8C99 → linear `out_data`=0x828A. With `NEURON_RELU_EN`, `out_data`=0x0000.
- **Saturation.**
  - bias=0x7C00, products 0x0800, 0x0800 → `out_data`=0x7FFF, `out_sat`=1.
  - bias=0xFC00, same magnitudes negative → 0xFFFF linear, 0x0000 with ReLU.
- **Sticky flags.**
  - First product has `prod_invalid`=1, second `prod_ovf`=1 → `out_err`=1, `out_sat`=1.
  - Next evaluation with clean flags → both 0.
  - Products 0x8000, 0x8000 with bias 0 → 0x0000.
- **Backpressure and stalls.**
  - `out_ready` held 0 for 5 cycles → `out_valid`/`out_data` stable; `start` pulses and `prod_valid` ignored; `prod_ready`=0. Release `out_ready` → IDLE the next cycle.
  - Gaps in `prod_valid` during ACC → same result as back-to-back.
- **Reset mid-operation.** Assert `rst` after one accepted product → next cycle all outputs 0 and `prod_ready`=0. A new evaluation with bias 0, products 0x0400, 0x0400 → 0x0800.
